// File: rtl/nand_flash_responder.sv
// nand_flash_responder
//   Device-side model of a NAND flash part. It decodes the controller's pin
//   activity, oversampled on PCLK, and serves a small flop array, a page
//   buffer, ID bytes and a status byte. R_B_n follows the busy timing.
//
// Ports
//   PCLK, PRESETN     : clock, asynchronous active-low reset
//   nCE, CLE, ALE     : chip enable (low), command / address latch enables
//   nWE, nRE          : write strobe (latches on rise), read strobe (low)
//   nWP               : write protect, active low
//   IO_IN             : bus from controller
//   IO_OUT, IO_OE     : bus to controller and its output enable
//   R_B_n             : ready/busy, 0 = busy
module nand_flash_responder #(
  parameter int unsigned PAGE_BYTES      = 16,
  parameter int unsigned NUM_PAGES       = 16,
  parameter int unsigned PAGES_PER_BLOCK = 4,
  parameter logic [31:0] ID_BYTES        = 32'hEC_F1_00_95,
  parameter int unsigned T_READ          = 8,
  parameter int unsigned T_PROG          = 20,
  parameter int unsigned T_ERASE         = 40,
  parameter int unsigned T_RST           = 4
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       nCE,
  input  logic       CLE,
  input  logic       ALE,
  input  logic       nWE,
  input  logic       nRE,
  input  logic       nWP,
  input  logic [7:0] IO_IN,
  output logic [7:0] IO_OUT,
  output logic       IO_OE,
  output logic       R_B_n
);

  localparam int unsigned CW = $clog2(PAGE_BYTES);
  localparam int unsigned RW = $clog2(NUM_PAGES);
  localparam int unsigned BW = $clog2(PAGES_PER_BLOCK);
  localparam int unsigned TW = 16;

  // Pin bundle {nCE, CLE, ALE, nWE, nRE, nWP, IO}; reset to the idle pin levels.
  localparam logic [13:0] PIN_IDLE = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA_IN, S_BUSY} state_t;
  typedef enum logic [1:0] {OP_ID, OP_READ, OP_PROG, OP_ERASE} op_t;
  typedef enum logic [1:0] {M_NONE, M_ID, M_STATUS, M_PAGE} mode_t;
  typedef enum logic [1:0] {C_NONE, C_READ, C_PROG, C_ERASE} commit_t;

  // ---------------- synchronizers and strobe edges ----------------
  logic [13:0] sync1, sync2;
  logic        we_prev, re_prev;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      sync1   <= PIN_IDLE;
      sync2   <= PIN_IDLE;
      we_prev <= 1'b1;
      re_prev <= 1'b1;
    end else begin
      sync1   <= {nCE, CLE, ALE, nWE, nRE, nWP, IO_IN};
      sync2   <= sync1;
      we_prev <= sync2[10];
      re_prev <= sync2[9];
    end
  end

  logic       s_nce, s_cle, s_ale, s_nwe, s_nre, s_nwp;
  logic [7:0] io_s;
  assign {s_nce, s_cle, s_ale, s_nwe, s_nre, s_nwp, io_s} = sync2;

  logic we_rise, re_rise, cmd_cyc, addr_cyc, data_cyc;
  assign we_rise  = s_nwe & ~we_prev & ~s_nce;
  assign re_rise  = s_nre & ~re_prev & ~s_nce;
  assign cmd_cyc  = we_rise &  s_cle & ~s_ale;
  assign addr_cyc = we_rise & ~s_cle &  s_ale;
  assign data_cyc = we_rise & ~s_cle & ~s_ale;

  // ---------------- control FSM ----------------
  state_t      state, state_nxt;
  op_t         op, op_nxt;
  commit_t     commit, commit_nxt;
  logic [1:0]  acnt, acnt_nxt;
  logic [TW-1:0] cnt, cnt_nxt;

  logic  fill_buf, wr_col, wr_row, wr_data, do_commit, fail_set, fail_clr, mode_set;
  mode_t mode, mode_val;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state  <= S_IDLE;
      op     <= OP_ID;
      commit <= C_NONE;
      acnt   <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      op     <= op_nxt;
      commit <= commit_nxt;
      acnt   <= acnt_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    op_nxt     = op;
    commit_nxt = commit;
    acnt_nxt   = acnt;
    cnt_nxt    = cnt;
    fill_buf   = 1'b0;
    wr_col     = 1'b0;
    wr_row     = 1'b0;
    wr_data    = 1'b0;
    do_commit  = 1'b0;
    fail_set   = 1'b0;
    fail_clr   = 1'b0;
    mode_set   = 1'b0;
    mode_val   = M_NONE;

    // Busy countdown runs independently of the strobes so that a status
    // command (or nCE high) never stalls it; 0xFF below may override it.
    if (state == S_BUSY) begin
      if (cnt == '0) begin
        state_nxt = S_IDLE;
        do_commit = 1'b1;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
    end

    if (cmd_cyc) begin
      if (io_s == 8'hFF) begin
        state_nxt  = S_BUSY;
        cnt_nxt    = TW'(T_RST - 1);
        commit_nxt = C_NONE;
        do_commit  = 1'b0;
        mode_set   = 1'b1;
        mode_val   = M_NONE;
      end else if (io_s == 8'h70) begin
        mode_set = 1'b1;
        mode_val = M_STATUS;
      end else if (state != S_BUSY) begin
        state_nxt = S_IDLE;
        case (io_s)
          8'h90: begin
            op_nxt    = OP_ID;
            acnt_nxt  = '0;
            state_nxt = S_ADDR;
            mode_set  = 1'b1;
            mode_val  = M_ID;
          end
          8'h00: begin
            op_nxt    = OP_READ;
            acnt_nxt  = '0;
            state_nxt = S_ADDR;
          end
          8'h80: begin
            op_nxt    = OP_PROG;
            acnt_nxt  = '0;
            state_nxt = S_ADDR;
            fill_buf  = 1'b1;
          end
          8'h60: begin
            op_nxt    = OP_ERASE;
            acnt_nxt  = '0;
            state_nxt = S_ADDR;
          end
          8'h30: begin
            if (state == S_ADDR && op == OP_READ && acnt == 2'd2) begin
              state_nxt  = S_BUSY;
              cnt_nxt    = TW'(T_READ - 1);
              commit_nxt = C_READ;
            end
          end
          8'h10: begin
            if (state == S_DATA_IN) begin
              state_nxt  = S_BUSY;
              cnt_nxt    = TW'(T_PROG - 1);
              commit_nxt = s_nwp ? C_PROG : C_NONE;
              fail_set   = ~s_nwp;
              fail_clr   = s_nwp;
            end
          end
          8'hD0: begin
            if (state == S_ADDR && op == OP_ERASE && acnt == 2'd1) begin
              state_nxt  = S_BUSY;
              cnt_nxt    = TW'(T_ERASE - 1);
              commit_nxt = s_nwp ? C_ERASE : C_NONE;
              fail_set   = ~s_nwp;
              fail_clr   = s_nwp;
            end
          end
          default: ;
        endcase
      end
    end else if (addr_cyc && state == S_ADDR) begin
      case (op)
        OP_ID: state_nxt = S_IDLE;
        OP_READ: begin
          if (acnt == 2'd0) begin
            wr_col   = 1'b1;
            acnt_nxt = 2'd1;
          end else if (acnt == 2'd1) begin
            wr_row   = 1'b1;
            acnt_nxt = 2'd2;
          end
        end
        OP_PROG: begin
          if (acnt == 2'd0) begin
            wr_col   = 1'b1;
            acnt_nxt = 2'd1;
          end else begin
            wr_row    = 1'b1;
            acnt_nxt  = 2'd2;
            state_nxt = S_DATA_IN;
          end
        end
        OP_ERASE: begin
          if (acnt == 2'd0) begin
            wr_row   = 1'b1;
            acnt_nxt = 2'd1;
          end
        end
        default: ;
      endcase
    end else if (data_cyc && state == S_DATA_IN) begin
      wr_data = 1'b1;
    end
  end

  assign R_B_n = (state != S_BUSY);

  // ---------------- datapath: array, page buffer, pointers ----------------
  logic [7:0]    mem  [NUM_PAGES][PAGE_BYTES];
  logic [7:0]    pbuf [PAGE_BYTES];
  logic [CW-1:0] ptr;
  logic [RW-1:0] row;
  logic [1:0]    idx;
  logic          fail;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      for (int unsigned p = 0; p < NUM_PAGES; p++)
        for (int unsigned b = 0; b < PAGE_BYTES; b++)
          mem[p][b] <= 8'hFF;
      for (int unsigned b = 0; b < PAGE_BYTES; b++)
        pbuf[b] <= 8'hFF;
      ptr  <= '0;
      row  <= '0;
      idx  <= '0;
      fail <= 1'b0;
      mode <= M_NONE;
    end else begin
      if (fill_buf)
        for (int unsigned b = 0; b < PAGE_BYTES; b++)
          pbuf[b] <= 8'hFF;
      if (wr_col) ptr <= io_s[CW-1:0];
      if (wr_row) row <= io_s[RW-1:0];
      if (wr_data) begin
        pbuf[ptr] <= io_s;
        ptr       <= ptr + 1'b1;
      end
      if (fail_set) fail <= 1'b1;
      if (fail_clr) fail <= 1'b0;
      if (mode_set) begin
        mode <= mode_val;
        if (mode_val == M_ID) idx <= '0;
      end
      if (re_rise) begin
        if (mode == M_ID)   idx <= idx + 1'b1;
        if (mode == M_PAGE) ptr <= ptr + 1'b1;
      end
      if (do_commit) begin
        case (commit)
          C_READ: begin
            for (int unsigned b = 0; b < PAGE_BYTES; b++)
              pbuf[b] <= mem[row][b];
            mode <= M_PAGE;
          end
          C_PROG: begin
            for (int unsigned b = 0; b < PAGE_BYTES; b++)
              mem[row][b] <= mem[row][b] & pbuf[b];
          end
          C_ERASE: begin
            // Every page sharing the row's block bits is erased.
            for (int unsigned p = 0; p < NUM_PAGES; p++)
              if ((RW'(p) >> BW) == (row >> BW))
                for (int unsigned b = 0; b < PAGE_BYTES; b++)
                  mem[p][b] <= 8'hFF;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- read output ----------------
  logic [7:0] cur_byte;

  always_comb begin
    cur_byte = '0;
    case (mode)
      M_ID: begin
        case (idx)
          2'd0:    cur_byte = ID_BYTES[31:24];
          2'd1:    cur_byte = ID_BYTES[23:16];
          2'd2:    cur_byte = ID_BYTES[15:8];
          default: cur_byte = ID_BYTES[7:0];
        endcase
      end
      M_STATUS: cur_byte = {s_nwp, R_B_n, 5'b00000, fail};
      M_PAGE:   cur_byte = pbuf[ptr];
      default:  cur_byte = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      IO_OUT <= '0;
      IO_OE  <= 1'b0;
    end else if (!s_nce && !s_nre && mode != M_NONE) begin
      IO_OUT <= cur_byte;
      IO_OE  <= 1'b1;
    end else begin
      IO_OUT <= '0;
      IO_OE  <= 1'b0;
    end
  end

endmodule

// File: doc/nand_flash_responder.md
Name: nand_flash_responder

Overview:
- Synthesizable NAND flash target model: the device end of the NAND pin interface driven by the team's APB NAND controller.
- Oversamples nCE/CLE/ALE/nWE/nRE/nWP/IO on PCLK and decodes command, address and data cycles.
- Serves a small flop-based array, page buffer, ID and status, and drives R_B_n busy timing.
- Used in controller benches and on-chip loopback tests in place of real flash.

Parameters:
- PAGE_BYTES, 16, bytes per page (power of 2); column index is col mod PAGE_BYTES.
- NUM_PAGES, 16, pages in array (power of 2); row index is row mod NUM_PAGES.
- PAGES_PER_BLOCK, 4, pages per erase block (power of 2).
- ID_BYTES, 32'hEC_F1_00_95, Read ID bytes, MSB byte first.
- T_READ, 8, PCLK cycles busy for page read.
- T_PROG, 20, PCLK cycles busy for program.
- T_ERASE, 40, PCLK cycles busy for erase.
- T_RST, 4, PCLK cycles busy for reset.

Ports:
- PCLK, in, 1, clock, the only clock in the block.
- PRESETN, in, 1, asynchronous active-low reset.
- nCE, in, 1, chip enable, active low.
- CLE, in, 1, command latch enable.
- ALE, in, 1, address latch enable.
- nWE, in, 1, write strobe; latches on rising edge.
- nRE, in, 1, read strobe, active low.
- nWP, in, 1, write protect, active low.
- IO_IN, in, 8, bus from controller.
- IO_OUT, out, 8, bus to controller.
- IO_OE, out, 1, output enable for IO_OUT.
- R_B_n, out, 1, ready/busy; 0 = busy.

Behaviour:
- Reset values:
  - IO_OUT=8'h00, IO_OE=0, R_B_n=1.
  - State IDLE, output mode NONE, status=8'hC0 with bit7 driven live from nWP.
  - Array contents after reset are all 8'hFF.
- Sampling:
  - All pins pass through 2-flop synchronizers.
  - nWE rise = synced nWE 0->1 while synced nCE=0.
  - Controller holds each strobe phase >=3 PCLK and IO stable across the nWE rise.
- Each nWE rise is classified as exactly one cycle type:
  - CLE=1, ALE=0: command cycle.
  - ALE=1, CLE=0: address cycle.
  - Both 0: data cycle.
  - Both 1: ignored.
- Main states:
  - IDLE: waiting for a command.
  - ADDR: collecting address bytes.
  - DATA_IN: accepting program data.
  - BUSY: R_B_n=0 with a down-counter running.
- Commands:
  - 0xFF: in any state, aborts a pending commit, enters BUSY for T_RST, then IDLE with output mode NONE.
  - 0x90: read ID. Expects 1 address cycle (value ignored). Output mode ID, byte index 0.
  - 0x70: read status. Legal in any state including BUSY. Output mode STATUS; the state is unchanged.
  - 0x00 read: 2 address cycles (col, row), then 0x30 enters BUSY for T_READ. At count end, page buffer is loaded from array[row]; output mode PAGE, pointer = col.
  - 0x80 program: page buffer is filled with 8'hFF, then 2 address cycles (col, row), then DATA_IN. Each data cycle writes buf[ptr] and increments ptr mod PAGE_BYTES. 0x10 enters BUSY for T_PROG. At count end, array[row] &= buf bytewise (bits only clear).
  - 0x60 erase: 1 address cycle (row), then 0xD0 enters BUSY for T_ERASE. At count end, every page in the block starting at row & ~(PAGES_PER_BLOCK-1) is set to 8'hFF.
  - Confirm (0x10/0xD0) with synced nWP=0: no array change; status bit0=1; busy time still applies.
  - Successful program/erase clears status bit0.
  - Unknown command, or out-of-sequence confirm: ignored, go to IDLE.
  - Any other command or any data/address cycle during BUSY: ignored.
  - Extra address cycles beyond the expected count: ignored.
- Status byte: bit7 = synced nWP, bit6 = ready (R_B_n), bit0 = fail, all others 0.
- Read output:
  - While synced nCE=0 and synced nRE=0 and output mode != NONE: IO_OE=1, IO_OUT = current byte (ID[idx], status, or buf[ptr]).
  - IO_OUT is valid 3 PCLK after nRE falls at the pins.
  - On synced nRE rise: idx increments mod 4 (ID) or ptr increments mod PAGE_BYTES (PAGE). STATUS does not advance.
  - nRE pulses in mode NONE: IO_OE stays 0.
- nCE high: IO_OE=0, strobes ignored; a BUSY countdown continues.
- R_B_n=0 exactly for the BUSY counter duration (T_x cycles, starting the PCLK after confirm is detected), then 1.
- PRESETN low mid-operation: immediate return to reset values; array reinitialised to 8'hFF.

Test Plan:
- ID read: 0x90, addr 0x00, four nRE pulses -> IO_OUT EC,F1,00,95, IO_OE=1 only while nRE low; fifth pulse -> EC.
- Program and read back:
  - Program col 0x02, row 0x03, data A5,5A, 0x10 -> R_B_n low 20 cycles.
  - Then 0x00,02,03,0x30, R_B_n low 8 cycles, 3 nRE pulses -> A5,5A,FF.
- Bit-clear semantics: program row 3 col 2 with 0x0F over the existing A5 -> readback 0x05.
- Erase: 0x60, row 0x06, 0xD0 -> busy 40 cycles; rows 4..7 read all FF; row 3 unchanged.
- Write protect: nWP=0, program row 1 -> array unchanged. 0x70 -> status 0x41; after nWP=1, a good program -> status 0xC0.
- Reset mid-busy and column wrap:
  - 0xFF during T_PROG -> busy ends after 4 cycles, page unchanged.
  - Read col 0x0F -> bytes at col 15 then col 0.
